if_fetch_unit: RTL and testbench
================================

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 The block SHALL take parameter RESET_PC, default 32'h0000_3000: the fetch PC loaded by reset.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port next_pc, input, 32 bits: next fetch address from the NPC mux, computed from pc_F.
REQ-005 The block SHALL have port stall, input, 1 bit: decode stage stalled; hold the IF/ID register and pc_F.
REQ-006 The block SHALL have port flush, input, 1 bit: discard the instruction entering decode this cycle.
REQ-007 The block SHALL have port imem_req, output, 1 bit: instruction memory read request.
REQ-008 The block SHALL have port imem_addr, output, 32 bits: word-aligned read address, equal to pc_F.
REQ-009 The block SHALL have port imem_ready, input, 1 bit: imem_rdata is valid this cycle for the request.
REQ-010 The block SHALL have port imem_rdata, input, 32 bits: fetched instruction word.
REQ-011 The block SHALL have port pc_F, output, 32 bits: current fetch PC, also fed to the NPC mux.
REQ-012 The block SHALL have ports instr_D, pc_D and pc8_D, each output, 32 bits: the IF/ID register holding the instruction, its PC, and that PC + 8.
REQ-013 The block SHALL have port valid_D, output, 1 bit: instr_D is a real instruction, not a bubble.

Function
REQ-014 The block SHALL implement a two-state FSM with states FETCH (request outstanding) and HOLD (fetched word buffered during a stall).
REQ-015 In FETCH, imem_req SHALL be 1; in HOLD, it SHALL be 0. imem_addr SHALL equal {pc_F[31:2],2'b00} at all times.
REQ-016 While imem_req=1 and imem_ready=0, pc_F and imem_addr SHALL stay stable.
REQ-017 In FETCH with imem_ready=1, stall=0 and flush=0, the next edge SHALL perform all of the following:
- instr_D <= imem_rdata, pc_D <= pc_F, pc8_D <= pc_F+8, valid_D <= 1;
- pc_F <= {next_pc[31:2],2'b00};
- the FSM stays in FETCH.
REQ-018 In FETCH with imem_ready=1 and stall=1, the next edge SHALL latch imem_rdata into an internal buffer and go to HOLD; the IF/ID register and pc_F SHALL hold.
REQ-019 In FETCH with imem_ready=0 and stall=0, the next edge SHALL load a bubble: instr_D=0, valid_D=0, pc_D and pc8_D unchanged. pc_F SHALL hold.
REQ-020 In HOLD with stall=1, all registers SHALL hold.
REQ-021 In HOLD with stall=0, the next edge SHALL load the IF/ID register from the buffer as in REQ-017, load pc_F from next_pc, and return to FETCH.
REQ-022 With flush=1 and stall=0, an instruction that would enter decode SHALL be replaced by a bubble, per REQ-019. pc_F SHALL still advance to next_pc, and the FSM SHALL transition as in REQ-017 or REQ-021.
REQ-023 When stall and flush are both 1, stall SHALL take priority and flush SHALL be ignored that cycle.
REQ-024 All PC arithmetic SHALL be 32-bit modulo 2^32, so 32'hFFFF_FFFC+8 wraps to 32'h0000_0004.
REQ-025 imem_rdata SHALL be sampled only when imem_ready=1 in FETCH; imem_ready in HOLD SHALL be ignored.

Reset
REQ-026 When reset=1 at an edge, the block SHALL set pc_F=RESET_PC, FSM=FETCH, instr_D=0, pc_D=0, pc8_D=0, valid_D=0, buffer=0, overriding stall, flush and imem_ready.
REQ-027 A reset during HOLD or an outstanding request SHALL discard buffered or arriving data, and imem_addr SHALL be RESET_PC in the first cycle after reset.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- Reset, then imem_ready=1 every cycle, next_pc=pc_F+4 -> pc_F goes 0x3000,0x3004,0x3008; pc_D=0x3000 with pc8_D=0x3008, valid_D=1 one cycle after the first fetch.
- imem_ready low 3 cycles at pc_F=0x3004 -> imem_addr held at 0x3004, three bubbles (valid_D=0, instr_D=0), then the 0x3004 instruction enters decode.
- stall=1 for 2 cycles while imem_ready=1 returns 0x8C010000 -> HOLD, imem_req=0, IF/ID unchanged; on release instr_D=0x8C010000 and pc_F=next_pc.
- flush=1 with imem_ready=1 and next_pc=0x3100 -> valid_D=0, instr_D=0, pc_F=0x3100.
- stall=1 and flush=1 together -> all state unchanged.
- reset asserted in HOLD -> pc_F=0x3000, valid_D=0, FETCH; the buffered word never appears on instr_D.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: drives the I-memory request at pc_F and fills the IF/ID
// register, buffering a word that returns while decode is stalled.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] next_pc,
    input  logic        stall,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_F,
    output logic [31:0] instr_D,
    output logic [31:0] pc_D,
    output logic [31:0] pc8_D,
    output logic        valid_D
);

    typedef enum logic {FETCH, HOLD} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcd_q, pcd_d;
    logic [31:0] pc8_q, pc8_d;
    logic [31:0] buf_q, buf_d;
    logic        valid_q, valid_d;

    logic        word_avail;
    logic        advance;
    logic [31:0] word;

    // A word is ready for decode either from the stall buffer or straight from memory.
    assign word_avail = (state_q == HOLD) || imem_ready;
    assign word       = (state_q == HOLD) ? buf_q : imem_rdata;
    assign advance    = !stall && word_avail;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   if (stall && imem_ready) state_d = HOLD;
            HOLD:    if (!stall) state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        imem_req = (state_q == FETCH);
    end

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pcd_d   = pcd_q;
        pc8_d   = pc8_q;
        valid_d = valid_q;
        buf_d   = buf_q;
        if (!stall) begin
            if (advance) begin
                pc_d = next_pc & ~32'h3;
            end
            // Missing data and flush both produce a bubble; PCs of the last real instruction stay.
            if (advance && !flush) begin
                instr_d = word;
                pcd_d   = pc_q;
                pc8_d   = pc_q + 32'd8;
                valid_d = 1'b1;
            end else begin
                instr_d = '0;
                valid_d = 1'b0;
            end
        end else if (state_q == FETCH && imem_ready) begin
            buf_d = imem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            instr_q <= '0;
            pcd_q   <= '0;
            pc8_q   <= '0;
            valid_q <= 1'b0;
            buf_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcd_q   <= pcd_d;
            pc8_q   <= pc8_d;
            valid_q <= valid_d;
            buf_q   <= buf_d;
        end
    end

    assign pc_F      = pc_q;
    assign imem_addr = pc_q & ~32'h3;
    assign instr_D   = instr_q;
    assign pc_D      = pcd_q;
    assign pc8_D     = pc8_q;
    assign valid_D   = valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed vector table, a reset-in-HOLD sequence and
// randomized traffic checked against a behavioural fetch model.
module tb_if_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset, stall, flush, imem_ready;
    logic [31:0] next_pc, imem_rdata;
    logic        imem_req, valid_D;
    logic [31:0] imem_addr, pc_F, instr_D, pc_D, pc8_D;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk        (clk),
        .reset      (reset),
        .next_pc    (next_pc),
        .stall      (stall),
        .flush      (flush),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .pc_F       (pc_F),
        .instr_D    (instr_D),
        .pc_D       (pc_D),
        .pc8_D      (pc8_D),
        .valid_D    (valid_D)
    );

    typedef struct {
        logic        rst, st, fl, rdy;
        logic [31:0] rdata, npc;
        logic [31:0] e_pc, e_instr, e_pcd, e_pc8;
        logic        e_valid, e_req;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int unsigned idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s [%0d]: got %08h expected %08h", name, idx, act, exp);
        end
    endtask

    task automatic drive_edge(input logic rst, input logic st, input logic fl, input logic rdy,
                              input logic [31:0] rdata, input logic [31:0] npc);
        reset      = rst;
        stall      = st;
        flush      = fl;
        imem_ready = rdy;
        imem_rdata = rdata;
        next_pc    = npc;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input int unsigned idx, input logic [31:0] e_pc,
                             input logic [31:0] e_instr, input logic [31:0] e_pcd,
                             input logic [31:0] e_pc8, input logic e_valid, input logic e_req);
        check("pc_F", idx, pc_F, e_pc);
        check("imem_addr", idx, imem_addr, e_pc & ~32'h3);
        check("instr_D", idx, instr_D, e_instr);
        check("pc_D", idx, pc_D, e_pcd);
        check("pc8_D", idx, pc8_D, e_pc8);
        check("valid_D", idx, {31'd0, valid_D}, {31'd0, e_valid});
        check("imem_req", idx, {31'd0, imem_req}, {31'd0, e_req});
    endtask

    function automatic vec_t mk(input logic rst, input logic st, input logic fl, input logic rdy,
                                input logic [31:0] rdata, input logic [31:0] npc,
                                input logic [31:0] e_pc, input logic [31:0] e_instr,
                                input logic [31:0] e_pcd, input logic [31:0] e_pc8,
                                input logic e_valid, input logic e_req);
        vec_t v;
        v.rst = rst; v.st = st; v.fl = fl; v.rdy = rdy; v.rdata = rdata; v.npc = npc;
        v.e_pc = e_pc; v.e_instr = e_instr; v.e_pcd = e_pcd; v.e_pc8 = e_pc8;
        v.e_valid = e_valid; v.e_req = e_req;
        return v;
    endfunction

    // Behavioural model: PC, an optional parked word, and the decode-side view.
    logic [31:0] m_pc, m_buf, m_instr, m_pcd, m_pc8;
    logic        m_parked, m_valid;

    task automatic model_step(input logic rst, input logic st, input logic fl, input logic rdy,
                              input logic [31:0] rdata, input logic [31:0] npc);
        logic [31:0] cur_pc;
        logic [31:0] got;
        cur_pc = m_pc;
        if (rst) begin
            m_pc = RST_PC; m_parked = 1'b0; m_buf = 0;
            m_instr = 0; m_pcd = 0; m_pc8 = 0; m_valid = 1'b0;
        end else if (st) begin
            if (!m_parked && rdy) begin
                m_parked = 1'b1;
                m_buf    = rdata;
            end
        end else if (m_parked || rdy) begin
            got      = m_parked ? m_buf : rdata;
            m_parked = 1'b0;
            m_pc     = {npc[31:2], 2'b00};
            if (fl) begin
                m_instr = 0; m_valid = 1'b0;
            end else begin
                m_instr = got; m_pcd = cur_pc; m_pc8 = cur_pc + 32'd8; m_valid = 1'b1;
            end
        end else begin
            m_instr = 0; m_valid = 1'b0;
        end
    endtask

    initial begin
        logic        r_rst, r_st, r_fl, r_rdy;
        logic [31:0] r_data, r_npc;

        reset = 1'b1; stall = 1'b0; flush = 1'b0; imem_ready = 1'b0;
        imem_rdata = '0; next_pc = '0;

        // rst st fl rdy rdata npc | pc_F instr pc_D pc8_D valid req
        vecs.push_back(mk(1,0,0,0, 32'h0,         32'h0,       32'h3000, 32'h0,        32'h0,    32'h0,    0, 1));
        vecs.push_back(mk(0,0,0,1, 32'hA000_0000, 32'h3004,    32'h3004, 32'hA000_0000, 32'h3000, 32'h3008, 1, 1));
        vecs.push_back(mk(0,0,0,0, 32'h1111_1111, 32'h3008,    32'h3004, 32'h0,        32'h3000, 32'h3008, 0, 1));
        vecs.push_back(mk(0,0,0,0, 32'h2222_2222, 32'h3008,    32'h3004, 32'h0,        32'h3000, 32'h3008, 0, 1));
        vecs.push_back(mk(0,0,0,0, 32'h3333_3333, 32'h3008,    32'h3004, 32'h0,        32'h3000, 32'h3008, 0, 1));
        vecs.push_back(mk(0,0,0,1, 32'hA000_0001, 32'h3008,    32'h3008, 32'hA000_0001, 32'h3004, 32'h300C, 1, 1));
        vecs.push_back(mk(0,1,0,1, 32'h8C01_0000, 32'h300C,    32'h3008, 32'hA000_0001, 32'h3004, 32'h300C, 1, 0));
        vecs.push_back(mk(0,1,0,1, 32'hDEAD_BEEF, 32'h300C,    32'h3008, 32'hA000_0001, 32'h3004, 32'h300C, 1, 0));
        vecs.push_back(mk(0,0,0,0, 32'h4444_4444, 32'h300C,    32'h300C, 32'h8C01_0000, 32'h3008, 32'h3010, 1, 1));
        vecs.push_back(mk(0,0,1,1, 32'hA000_0002, 32'h3100,    32'h3100, 32'h0,        32'h3008, 32'h3010, 0, 1));
        vecs.push_back(mk(0,0,0,1, 32'hA000_0003, 32'h3104,    32'h3104, 32'hA000_0003, 32'h3100, 32'h3108, 1, 1));
        vecs.push_back(mk(0,1,1,0, 32'h5555_5555, 32'h3200,    32'h3104, 32'hA000_0003, 32'h3100, 32'h3108, 1, 1));
        vecs.push_back(mk(0,1,1,1, 32'hB000_0000, 32'h3200,    32'h3104, 32'hA000_0003, 32'h3100, 32'h3108, 1, 0));
        vecs.push_back(mk(0,0,1,0, 32'h6666_6666, 32'h3300,    32'h3300, 32'h0,        32'h3100, 32'h3108, 0, 1));
        vecs.push_back(mk(0,0,0,1, 32'hA000_0004, 32'h3301,    32'h3300, 32'hA000_0004, 32'h3300, 32'h3308, 1, 1));
        vecs.push_back(mk(0,0,0,1, 32'hA000_0005, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hA000_0005, 32'h3300, 32'h3308, 1, 1));
        vecs.push_back(mk(0,0,0,1, 32'hA000_0006, 32'h0,       32'h0,    32'hA000_0006, 32'hFFFF_FFFC, 32'h0000_0004, 1, 1));

        @(negedge clk);
        foreach (vecs[i]) begin
            drive_edge(vecs[i].rst, vecs[i].st, vecs[i].fl, vecs[i].rdy, vecs[i].rdata, vecs[i].npc);
            check_all(i, vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_pcd, vecs[i].e_pc8,
                      vecs[i].e_valid, vecs[i].e_req);
        end

        // Reset while a stalled word sits in the buffer: it must never reach decode.
        drive_edge(0, 0, 0, 1, 32'hA000_0007, 32'h0000_0010);
        drive_edge(0, 1, 0, 1, 32'hBEEF_0001, 32'h0000_0014);
        check("hold_req", 100, {31'd0, imem_req}, 32'd0);
        drive_edge(1, 1, 1, 1, 32'hCAFE_0002, 32'h0000_0018);
        check_all(101, 32'h3000, 32'h0, 32'h0, 32'h0, 0, 1);
        drive_edge(0, 0, 0, 0, 32'hBEEF_0001, 32'h3004);
        check_all(102, 32'h3000, 32'h0, 32'h0, 32'h0, 0, 1);
        drive_edge(0, 0, 0, 1, 32'hA000_0008, 32'h3004);
        check_all(103, 32'h3004, 32'hA000_0008, 32'h3000, 32'h3008, 1, 1);

        // Randomized traffic against the model.
        model_step(1, 0, 0, 0, 0, 0);
        drive_edge(1, 0, 0, 0, 0, 0);
        check_all(200, m_pc, m_instr, m_pcd, m_pc8, m_valid, !m_parked);
        for (int unsigned k = 0; k < 400; k++) begin
            r_rst  = ($urandom_range(99) < 3);
            r_st   = ($urandom_range(99) < 30);
            r_fl   = ($urandom_range(99) < 15);
            r_rdy  = ($urandom_range(99) < 65);
            r_data = $urandom;
            r_npc  = ($urandom_range(3) == 0) ? $urandom : m_pc + 32'd4;
            model_step(r_rst, r_st, r_fl, r_rdy, r_data, r_npc);
            drive_edge(r_rst, r_st, r_fl, r_rdy, r_data, r_npc);
            check_all(300 + k, m_pc, m_instr, m_pcd, m_pc8, m_valid, !m_parked);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
